// File: rtl/port_b_mode1_handshake_if.sv
// Port B Mode 1 handshake bundle: CPU-side strobes and data, port B pins
// and the port C handshake bits (PC0 INTR, PC1 IBF/OBF_n, PC2 STB_n/ACK_n).
interface port_b_mode1_handshake_if #(
    parameter int DATA_W = 8
);
    logic              mode1_en;
    logic              dir_in;
    logic              inte_wr;
    logic              inte_val;
    logic              cpu_wr;
    logic              cpu_rd;
    logic [DATA_W-1:0] cpu_din;
    logic [DATA_W-1:0] cpu_dout;
    logic [DATA_W-1:0] pb_in;
    logic [DATA_W-1:0] pb_out;
    logic              pb_oe;
    logic              stb_n;
    logic              ack_n;
    logic              ibf;
    logic              obf_n;
    logic              intr;

    // Control/peripheral side: drives the strobes, watches the flags.
    modport master (
        output mode1_en, dir_in, inte_wr, inte_val, cpu_wr, cpu_rd, cpu_din,
               pb_in, stb_n, ack_n,
        input  cpu_dout, pb_out, pb_oe, ibf, obf_n, intr
    );

    // Handshake engine side.
    modport slave (
        input  mode1_en, dir_in, inte_wr, inte_val, cpu_wr, cpu_rd, cpu_din,
               pb_in, stb_n, ack_n,
        output cpu_dout, pb_out, pb_oe, ibf, obf_n, intr
    );
endinterface

// File: rtl/port_b_mode1_handshake.sv
// Strobed (Mode 1) handshake engine for PPI port B.
// Input direction latches pin data on a STB_n fall and raises IBF/INTR;
// output direction holds CPU data, drives OBF_n low and waits for ACK_n.
// STB_n/ACK_n are asynchronous and pass through a synchronizer; edge
// detection stays masked until the synchronizer has been refilled with real
// pin samples after reset, so a line already low at release is not mistaken
// for a fresh fall.
module port_b_mode1_handshake #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic                     clk,
    input logic                     rst_n,
    port_b_mode1_handshake_if.slave bus
);
    localparam int PRIME_CYC = SYNC_STAGES + 1;
    localparam int PRIME_W   = $clog2(PRIME_CYC + 1);

    typedef enum logic [0:0] {IN_EMPTY = 1'b0, IN_FULL = 1'b1} in_state_t;
    typedef enum logic [1:0] {OUT_EMPTY = 2'd0, OUT_FULL = 2'd1, OUT_ACKED = 2'd2} out_state_t;

    in_state_t         in_state_r,  in_state_nx_s;
    out_state_t        out_state_r, out_state_nx_s;
    logic [DATA_W-1:0] cpu_dout_r,  cpu_dout_nx_s;
    logic [DATA_W-1:0] pb_out_r,    pb_out_nx_s;
    logic              ibf_r,       ibf_nx_s;
    logic              obf_n_r,     obf_n_nx_s;
    logic              intr_r,      intr_fsm_s,  intr_nx_s;
    logic              inte_r,      inte_nx_s;
    logic              pb_oe_r;
    logic              dir_r;

    logic [SYNC_STAGES-1:0] stb_sync_r;
    logic [SYNC_STAGES-1:0] ack_sync_r;
    logic                   stb_d_r;
    logic                   ack_d_r;
    logic [PRIME_W-1:0]     prime_cnt_r;
    logic                   primed_s;
    logic                   stb_fall_s, stb_rise_s;
    logic                   ack_fall_s, ack_rise_s;
    logic                   reconf_s;
    logic                   inte_clr_s;

    assign primed_s   = (prime_cnt_r == PRIME_W'(PRIME_CYC));
    assign stb_fall_s = primed_s &  stb_d_r & ~stb_sync_r[SYNC_STAGES-1];
    assign stb_rise_s = primed_s & ~stb_d_r &  stb_sync_r[SYNC_STAGES-1];
    assign ack_fall_s = primed_s &  ack_d_r & ~ack_sync_r[SYNC_STAGES-1];
    assign ack_rise_s = primed_s & ~ack_d_r &  ack_sync_r[SYNC_STAGES-1];

    // Leaving Mode 1 or flipping direction abandons any handshake in flight.
    assign reconf_s   = ~bus.mode1_en | (bus.dir_in ^ dir_r);
    assign inte_clr_s = bus.inte_wr & ~bus.inte_val;
    assign intr_nx_s  = intr_fsm_s & ~inte_clr_s;

    // Synchronize the peripheral strobes and track synchronizer refill after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb_sync_r  <= {SYNC_STAGES{1'b1}};
            ack_sync_r  <= {SYNC_STAGES{1'b1}};
            stb_d_r     <= 1'b1;
            ack_d_r     <= 1'b1;
            prime_cnt_r <= {PRIME_W{1'b0}};
        end else begin
            stb_sync_r <= {stb_sync_r[SYNC_STAGES-2:0], bus.stb_n};
            ack_sync_r <= {ack_sync_r[SYNC_STAGES-2:0], bus.ack_n};
            stb_d_r    <= stb_sync_r[SYNC_STAGES-1];
            ack_d_r    <= ack_sync_r[SYNC_STAGES-1];
            if (!primed_s) begin
                prime_cnt_r <= prime_cnt_r + PRIME_W'(1);
            end
        end
    end

    // Handshake state, latches and flags register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_state_r  <= IN_EMPTY;
            out_state_r <= OUT_EMPTY;
            cpu_dout_r  <= {DATA_W{1'b0}};
            pb_out_r    <= {DATA_W{1'b0}};
            ibf_r       <= 1'b0;
            obf_n_r     <= 1'b1;
            intr_r      <= 1'b0;
            inte_r      <= 1'b0;
            pb_oe_r     <= 1'b0;
            dir_r       <= 1'b0;
        end else begin
            in_state_r  <= in_state_nx_s;
            out_state_r <= out_state_nx_s;
            cpu_dout_r  <= cpu_dout_nx_s;
            pb_out_r    <= pb_out_nx_s;
            ibf_r       <= ibf_nx_s;
            obf_n_r     <= obf_n_nx_s;
            intr_r      <= intr_nx_s;
            inte_r      <= inte_nx_s;
            pb_oe_r     <= bus.mode1_en & ~bus.dir_in;
            dir_r       <= bus.dir_in;
        end
    end

    // Next-state and flag logic for both handshake directions.
    always_comb begin
        in_state_nx_s  = in_state_r;
        out_state_nx_s = out_state_r;
        cpu_dout_nx_s  = cpu_dout_r;
        pb_out_nx_s    = pb_out_r;
        ibf_nx_s       = ibf_r;
        obf_n_nx_s     = obf_n_r;
        intr_fsm_s     = intr_r;
        inte_nx_s      = inte_r;

        if (bus.inte_wr) begin
            inte_nx_s = bus.inte_val;
        end else begin
            inte_nx_s = inte_r;
        end

        if (reconf_s) begin
            in_state_nx_s  = IN_EMPTY;
            out_state_nx_s = OUT_EMPTY;
            ibf_nx_s       = 1'b0;
            obf_n_nx_s     = 1'b1;
            intr_fsm_s     = 1'b0;
        end else if (bus.dir_in) begin
            case (in_state_r)
                IN_EMPTY: begin
                    if (stb_fall_s) begin
                        cpu_dout_nx_s = bus.pb_in;
                        ibf_nx_s      = 1'b1;
                        in_state_nx_s = IN_FULL;
                    end else begin
                        in_state_nx_s = IN_EMPTY;
                    end
                end
                IN_FULL: begin
                    if (stb_fall_s) begin
                        // Overrun relatch; a coincident read only clears intr.
                        cpu_dout_nx_s = bus.pb_in;
                        ibf_nx_s      = 1'b1;
                        if (bus.cpu_rd) begin
                            intr_fsm_s = 1'b0;
                        end else begin
                            intr_fsm_s = intr_r;
                        end
                    end else if (bus.cpu_rd) begin
                        ibf_nx_s      = 1'b0;
                        intr_fsm_s    = 1'b0;
                        in_state_nx_s = IN_EMPTY;
                    end else if (stb_rise_s && inte_r) begin
                        intr_fsm_s = 1'b1;
                    end else begin
                        in_state_nx_s = IN_FULL;
                    end
                end
                default: begin
                    in_state_nx_s = IN_EMPTY;
                end
            endcase
        end else begin
            if (bus.cpu_wr) begin
                // A CPU write overrides any coincident acknowledge edge.
                pb_out_nx_s    = bus.cpu_din;
                obf_n_nx_s     = 1'b0;
                intr_fsm_s     = 1'b0;
                out_state_nx_s = OUT_FULL;
            end else begin
                case (out_state_r)
                    OUT_FULL: begin
                        if (ack_fall_s) begin
                            obf_n_nx_s     = 1'b1;
                            out_state_nx_s = OUT_ACKED;
                        end else begin
                            out_state_nx_s = OUT_FULL;
                        end
                    end
                    OUT_ACKED: begin
                        if (ack_rise_s) begin
                            intr_fsm_s     = inte_r;
                            out_state_nx_s = OUT_EMPTY;
                        end else begin
                            out_state_nx_s = OUT_ACKED;
                        end
                    end
                    OUT_EMPTY: begin
                        out_state_nx_s = OUT_EMPTY;
                    end
                    default: begin
                        out_state_nx_s = OUT_EMPTY;
                    end
                endcase
            end
        end
    end

    assign bus.cpu_dout = cpu_dout_r;
    assign bus.pb_out   = pb_out_r;
    assign bus.pb_oe    = pb_oe_r;
    assign bus.ibf      = ibf_r;
    assign bus.obf_n    = obf_n_r;
    assign bus.intr     = intr_r;
endmodule

// File: tb/tb_port_b_mode1_handshake.sv
// Directed bench for the port B Mode 1 handshake engine: a per-cycle vector
// table for the main input/output/INTE scenarios plus hand-written collision,
// mode-change and reset sequences.
module tb_port_b_mode1_handshake;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    port_b_mode1_handshake_if #(.DATA_W(8)) bus ();

    port_b_mode1_handshake #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ctl = {mode1_en, dir_in, inte_wr, inte_val, cpu_wr, cpu_rd, stb_n, ack_n}
    // eflg = {ibf, obf_n, intr, pb_oe}, all expected just after the edge
    typedef struct {
        logic [7:0] ctl;
        logic [7:0] din;
        logic [7:0] pbin;
        logic [3:0] eflg;
        logic [7:0] edout;
        logic [7:0] epbout;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic [7:0] ctl, input logic [7:0] din,
                               input logic [7:0] pbin, input logic [3:0] eflg,
                               input logic [7:0] edout, input logic [7:0] epbout);
        vec_t r;
        r.ctl = ctl; r.din = din; r.pbin = pbin;
        r.eflg = eflg; r.edout = edout; r.epbout = epbout;
        return r;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] eflg,
                           input logic [7:0] edout, input logic [7:0] epbout);
        chk({tag, ".ibf"},      {7'd0, bus.ibf},   {7'd0, eflg[3]});
        chk({tag, ".obf_n"},    {7'd0, bus.obf_n}, {7'd0, eflg[2]});
        chk({tag, ".intr"},     {7'd0, bus.intr},  {7'd0, eflg[1]});
        chk({tag, ".pb_oe"},    {7'd0, bus.pb_oe}, {7'd0, eflg[0]});
        chk({tag, ".cpu_dout"}, bus.cpu_dout, edout);
        chk({tag, ".pb_out"},   bus.pb_out,   epbout);
    endtask

    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply(input vec_t r);
        {bus.mode1_en, bus.dir_in, bus.inte_wr, bus.inte_val,
         bus.cpu_wr, bus.cpu_rd, bus.stb_n, bus.ack_n} = r.ctl;
        bus.cpu_din = r.din;
        bus.pb_in   = r.pbin;
    endtask

    initial begin
        // input path, INTE=1
        tbl.push_back(v(8'b11110011, 8'h00, 8'hA5, 4'b0100, 8'h00, 8'h00));
        tbl.push_back(v(8'b11000001, 8'h00, 8'hA5, 4'b0100, 8'h00, 8'h00));
        tbl.push_back(v(8'b11000001, 8'h00, 8'hA5, 4'b0100, 8'h00, 8'h00));
        tbl.push_back(v(8'b11000001, 8'h00, 8'hA5, 4'b1100, 8'hA5, 8'h00));
        tbl.push_back(v(8'b11000001, 8'h00, 8'hA5, 4'b1100, 8'hA5, 8'h00));
        tbl.push_back(v(8'b11000011, 8'h00, 8'h00, 4'b1100, 8'hA5, 8'h00));
        tbl.push_back(v(8'b11000011, 8'h00, 8'h00, 4'b1100, 8'hA5, 8'h00));
        tbl.push_back(v(8'b11000011, 8'h00, 8'h00, 4'b1110, 8'hA5, 8'h00));
        tbl.push_back(v(8'b11000111, 8'h00, 8'h00, 4'b0100, 8'hA5, 8'h00));
        tbl.push_back(v(8'b11000011, 8'h00, 8'h00, 4'b0100, 8'hA5, 8'h00));
        // output path, INTE=1
        tbl.push_back(v(8'b10000011, 8'h00, 8'h00, 4'b0101, 8'hA5, 8'h00));
        tbl.push_back(v(8'b10001011, 8'h3C, 8'h00, 4'b0001, 8'hA5, 8'h3C));
        tbl.push_back(v(8'b10000010, 8'h00, 8'h00, 4'b0001, 8'hA5, 8'h3C));
        tbl.push_back(v(8'b10000010, 8'h00, 8'h00, 4'b0001, 8'hA5, 8'h3C));
        tbl.push_back(v(8'b10000010, 8'h00, 8'h00, 4'b0101, 8'hA5, 8'h3C));
        tbl.push_back(v(8'b10000011, 8'h00, 8'h00, 4'b0101, 8'hA5, 8'h3C));
        tbl.push_back(v(8'b10000011, 8'h00, 8'h00, 4'b0101, 8'hA5, 8'h3C));
        tbl.push_back(v(8'b10000011, 8'h00, 8'h00, 4'b0111, 8'hA5, 8'h3C));
        tbl.push_back(v(8'b10001011, 8'hC3, 8'h00, 4'b0001, 8'hA5, 8'hC3));
        // input path, INTE=0, then a late INTE set must not raise intr
        tbl.push_back(v(8'b11100011, 8'h00, 8'h96, 4'b0100, 8'hA5, 8'hC3));
        tbl.push_back(v(8'b11000001, 8'h00, 8'h96, 4'b0100, 8'hA5, 8'hC3));
        tbl.push_back(v(8'b11000001, 8'h00, 8'h96, 4'b0100, 8'hA5, 8'hC3));
        tbl.push_back(v(8'b11000001, 8'h00, 8'h96, 4'b1100, 8'h96, 8'hC3));
        tbl.push_back(v(8'b11000001, 8'h00, 8'h96, 4'b1100, 8'h96, 8'hC3));
        tbl.push_back(v(8'b11000011, 8'h00, 8'h96, 4'b1100, 8'h96, 8'hC3));
        tbl.push_back(v(8'b11000011, 8'h00, 8'h96, 4'b1100, 8'h96, 8'hC3));
        tbl.push_back(v(8'b11000011, 8'h00, 8'h96, 4'b1100, 8'h96, 8'hC3));
        tbl.push_back(v(8'b11110011, 8'h00, 8'h96, 4'b1100, 8'h96, 8'hC3));
        tbl.push_back(v(8'b11000111, 8'h00, 8'h96, 4'b0100, 8'h96, 8'hC3));

        // reset and idle inputs
        rst_n = 1'b0;
        apply(v(8'b00000011, 8'h00, 8'h00, 4'b0000, 8'h00, 8'h00));
        cyc(2);
        chk_all("reset", 4'b0100, 8'h00, 8'h00);
        rst_n = 1'b1;
        cyc(5);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            cyc(1);
            chk_all($sformatf("row%0d", i), tbl[i].eflg, tbl[i].edout, tbl[i].epbout);
        end
        apply(v(8'b11000011, 8'h00, 8'h00, 4'b0000, 8'h00, 8'h00));

        // input collision: strobe fall aligned with cpu_rd
        bus.pb_in = 8'h11; bus.stb_n = 1'b0; cyc(3);
        chk("col_in.ibf1", {7'd0, bus.ibf}, 8'h01);
        chk("col_in.dout1", bus.cpu_dout, 8'h11);
        bus.stb_n = 1'b1; cyc(3);
        chk("col_in.intr_set", {7'd0, bus.intr}, 8'h01);
        bus.pb_in = 8'h5A; bus.stb_n = 1'b0; cyc(2);
        chk("col_in.pre_intr", {7'd0, bus.intr}, 8'h01);
        bus.cpu_rd = 1'b1; cyc(1); bus.cpu_rd = 1'b0;
        chk("col_in.ibf", {7'd0, bus.ibf}, 8'h01);
        chk("col_in.dout", bus.cpu_dout, 8'h5A);
        chk("col_in.intr", {7'd0, bus.intr}, 8'h00);
        bus.stb_n = 1'b1; cyc(3);
        chk("mode.pre_intr", {7'd0, bus.intr}, 8'h01);

        // leaving Mode 1 from IN_FULL
        bus.mode1_en = 1'b0; cyc(1);
        chk("mode.ibf", {7'd0, bus.ibf}, 8'h00);
        chk("mode.intr", {7'd0, bus.intr}, 8'h00);
        chk("mode.dout", bus.cpu_dout, 8'h5A);

        // output collisions
        bus.mode1_en = 1'b1; bus.dir_in = 1'b0; cyc(1);
        chk("col_out.oe", {7'd0, bus.pb_oe}, 8'h01);
        bus.cpu_wr = 1'b1; bus.cpu_din = 8'h77; cyc(1); bus.cpu_wr = 1'b0;
        chk("col_out.obf0", {7'd0, bus.obf_n}, 8'h00);
        bus.ack_n = 1'b0; cyc(2);
        bus.cpu_wr = 1'b1; bus.cpu_din = 8'h88; cyc(1); bus.cpu_wr = 1'b0;
        chk("col_out.obf", {7'd0, bus.obf_n}, 8'h00);
        chk("col_out.pb_out", bus.pb_out, 8'h88);
        cyc(1);
        chk("col_out.obf_hold", {7'd0, bus.obf_n}, 8'h00);
        bus.ack_n = 1'b1; cyc(3);
        chk("col_out.rise_ign", {7'd0, bus.intr}, 8'h00);
        bus.ack_n = 1'b0; cyc(3);
        chk("col_out.obf_ack", {7'd0, bus.obf_n}, 8'h01);
        bus.ack_n = 1'b1; cyc(2);
        bus.cpu_wr = 1'b1; bus.cpu_din = 8'h99; cyc(1); bus.cpu_wr = 1'b0;
        chk("col_rise.intr", {7'd0, bus.intr}, 8'h00);
        chk("col_rise.obf", {7'd0, bus.obf_n}, 8'h00);
        chk("col_rise.pb_out", bus.pb_out, 8'h99);

        // clearing INTE drops a pending intr
        bus.ack_n = 1'b0; cyc(3);
        bus.ack_n = 1'b1; cyc(3);
        chk("inte_clr.pre", {7'd0, bus.intr}, 8'h01);
        bus.inte_wr = 1'b1; bus.inte_val = 1'b0; cyc(1); bus.inte_wr = 1'b0;
        chk("inte_clr.intr", {7'd0, bus.intr}, 8'h00);

        // asynchronous reset mid-OUT_FULL
        bus.cpu_wr = 1'b1; bus.cpu_din = 8'hAB; cyc(1); bus.cpu_wr = 1'b0;
        chk_all("full", 4'b0001, 8'h5A, 8'hAB);
        #2 rst_n = 1'b0;
        #1 chk_all("async_rst", 4'b0100, 8'h00, 8'h00);

        // strobe already low at reset release is not a fall
        bus.dir_in = 1'b1; bus.stb_n = 1'b0; bus.pb_in = 8'hC7;
        cyc(2);
        rst_n = 1'b1;
        cyc(6);
        chk("low_rel.ibf", {7'd0, bus.ibf}, 8'h00);
        bus.stb_n = 1'b1; cyc(3);
        bus.stb_n = 1'b0; cyc(2);
        chk("low_rel.lat", {7'd0, bus.ibf}, 8'h00);
        cyc(1);
        chk("low_rel.ibf1", {7'd0, bus.ibf}, 8'h01);
        chk("low_rel.dout", bus.cpu_dout, 8'hC7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/port_b_mode1_handshake.md
Name: port_b_mode1_handshake

Overview:
- Strobed (Mode 1) handshake engine for PPI port B; the peripheral-facing counterpart of the plain bidirectional port B path.
- Input direction: latches peripheral data on STB_n and raises IBF/INTR for the CPU. Output direction: holds CPU-written data, drives OBF_n and waits for ACK_n.
- Sits between the CPU-side bus/control logic and the port B pins plus port C handshake bits (PC0 INTR, PC1 IBF/OBF_n, PC2 STB_n/ACK_n).

Parameters:
- DATA_W, 8, port data width.
- SYNC_STAGES, 2, flip-flop stages synchronizing stb_n/ack_n (minimum 2).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- mode1_en  input  1  1 = port B in Mode 1 (from the control word); 0 = handshake disabled.
- dir_in  input  1  1 = strobed input, 0 = strobed output.
- inte_wr  input  1  one-cycle pulse: load INTE from inte_val (port C bit set/reset).
- inte_val  input  1  new INTE value.
- cpu_wr  input  1  one-cycle CPU write strobe to port B.
- cpu_rd  input  1  one-cycle CPU read strobe of port B.
- cpu_din  input  DATA_W  CPU write data.
- cpu_dout  output  DATA_W  input latch contents, presented to the CPU.
- pb_in  input  DATA_W  port B pins, sampled value.
- pb_out  output  DATA_W  port B output latch.
- pb_oe  output  1  port B pin drive enable.
- stb_n  input  1  peripheral strobe (PC2, input mode), asynchronous.
- ack_n  input  1  peripheral acknowledge (PC2, output mode), asynchronous.
- ibf  output  1  input buffer full (PC1, input mode).
- obf_n  output  1  output buffer full, active-low (PC1, output mode).
- intr  output  1  interrupt request (PC0).

Behaviour:
- Reset values (async, rst_n low): cpu_dout 0, pb_out 0, pb_oe 0, ibf 0, obf_n 1, intr 0, INTE 0, all sync flops 1, FSM in IN_EMPTY/OUT_EMPTY.
- Sync: stb_n and ack_n pass through SYNC_STAGES flops. A one-flop delayed copy forms fall/rise pulses.
- Latency: a flag change occurs on the edge after the edge pulse is detected. Pin fall to ibf high is SYNC_STAGES+1 cycles.
- pb_oe = mode1_en & ~dir_in (combinational from the registered mode inputs).
- When mode1_en=0, or dir_in changes, on the next edge: ibf 0, obf_n 1, intr 0, FSM returns to its EMPTY state. Latches and INTE keep their values.
- inte_wr loads INTE in any mode. Clearing INTE drops intr on the next edge. Setting INTE does not retroactively raise intr.
- Input FSM (mode1_en & dir_in):
  - IN_EMPTY: on stb fall, cpu_dout <= pb_in, ibf <= 1, go to IN_FULL.
  - IN_FULL: stb rise with INTE=1 sets intr <= 1.
  - IN_FULL: cpu_rd sets intr <= 0 and ibf <= 0, then go to IN_EMPTY.
  - IN_FULL: a further stb fall overwrites cpu_dout (overrun, no error flag).
  - Simultaneous stb fall and cpu_rd: the strobe wins. Data is relatched, ibf stays 1, intr is cleared.
- Output FSM (mode1_en & ~dir_in):
  - Any state: cpu_wr sets pb_out <= cpu_din, obf_n <= 0, intr <= 0, go to OUT_FULL.
  - OUT_FULL: ack fall sets obf_n <= 1, go to OUT_ACKED.
  - OUT_ACKED: ack rise with INTE=1 sets intr <= 1, go to OUT_EMPTY.
  - OUT_EMPTY: ack edges are ignored.
  - Simultaneous cpu_wr and ack fall: the write wins. obf_n stays 0, state stays OUT_FULL.
  - Simultaneous cpu_wr and ack rise: the write wins and intr stays 0.
- Bus timing: cpu_rd does not gate cpu_dout; the value is valid continuously. pb_out holds until the next cpu_wr or reset.
- Reset mid-handshake: every flag returns to its reset value immediately. A strobe already low at release is not detected until it rises and falls again.

Test Plan:
- Reset: rst_n low mid-OUT_FULL → obf_n=1, intr=0, pb_out=0, pb_oe=0 asynchronously, before any clock edge.
- Input path: mode1_en=1, dir_in=1, INTE=1, pb_in=8'hA5, pulse stb_n low 4 cycles → ibf=1 exactly SYNC_STAGES+1 cycles after the fall, cpu_dout=8'hA5, intr=1 after the rise; cpu_rd → ibf=0, intr=0 next edge.
- Output path: dir_in=0, INTE=1, cpu_wr with 8'h3C → pb_out=8'h3C, obf_n=0, pb_oe=1; ack_n pulse → obf_n=1 after the fall, intr=1 after the rise; next cpu_wr → intr=0.
- INTE=0: repeat the input scenario → ibf behaves the same and intr stays 0 throughout.
- Collisions: a stb fall aligned with cpu_rd carrying new pb_in=8'h5A → ibf stays 1, cpu_dout=8'h5A, intr=0. A cpu_wr aligned with an ack fall → obf_n stays 0.
- Mode change: in IN_FULL with intr=1, deassert mode1_en → ibf=0, intr=0 next edge and cpu_dout is retained.
